// File: rtl/alu_pkg.sv
// Shared constants for the alu and its registered command front end alu_seq.
// Holds the default widths and the opcode encoding.
package alu_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_OPERATION = 3;
   localparam int unsigned DEF_SHIFT     = 3;

   localparam logic [DEF_OPERATION-1:0] OP_ADD = DEF_OPERATION'(0);
   localparam logic [DEF_OPERATION-1:0] OP_SUB = DEF_OPERATION'(1);
   localparam logic [DEF_OPERATION-1:0] OP_AND = DEF_OPERATION'(2);
   localparam logic [DEF_OPERATION-1:0] OP_OR  = DEF_OPERATION'(3);
   localparam logic [DEF_OPERATION-1:0] OP_XOR = DEF_OPERATION'(4);
   localparam logic [DEF_OPERATION-1:0] OP_NOR = DEF_OPERATION'(5);
   localparam logic [DEF_OPERATION-1:0] OP_SLL = DEF_OPERATION'(6);
   localparam logic [DEF_OPERATION-1:0] OP_SRL = DEF_OPERATION'(7);

endpackage

// File: rtl/alu.sv
// Combinational alu: arithmetic, logic and shift ops with zero and signed-overflow flags.
// Overflow is only meaningful for ADD/SUB and reads 0 for every other opcode.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned OPERATION = DEF_OPERATION,
   parameter int unsigned SHIFT     = DEF_SHIFT
) (
   input  logic [OPERATION-1:0] op,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic [SHIFT-1:0]     shamt,
   input  logic                 carry,
   output logic [WIDTH-1:0]     result_c,
   output logic                 zero_c,
   output logic                 overflow_c
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum        = x + y + WIDTH'(carry);
      diff       = x - y;
      result_c   = '0;
      overflow_c = 1'b0;
      case (op)
         OP_ADD: begin
            result_c   = sum;
            // Same-sign operands producing an opposite-sign sum.
            overflow_c = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            result_c   = diff;
            overflow_c = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
         end
         OP_AND:  result_c = x & y;
         OP_OR:   result_c = x | y;
         OP_XOR:  result_c = x ^ y;
         OP_NOR:  result_c = ~(x | y);
         OP_SLL:  result_c = x << shamt;
         OP_SRL:  result_c = x >> shamt;
         default: result_c = '0;
      endcase
      zero_c = (result_c == '0);
   end

endmodule

// File: rtl/alu_seq.sv
// Two-stage valid/ready front end for the alu, with chain mode feeding the last result back as x.
// Define ALU_SEQ_STICKY_OVF_EN to add the ovf_sticky / ovf_clear overflow latch.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned OPERATION = DEF_OPERATION,
   parameter int unsigned SHIFT     = DEF_SHIFT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [OPERATION-1:0] cmd_op,
   input  logic [WIDTH-1:0]     cmd_x,
   input  logic [WIDTH-1:0]     cmd_y,
   input  logic [SHIFT-1:0]     cmd_shamt,
   input  logic                 cmd_carry,
   input  logic                 cmd_chain,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_result,
   output logic                 rsp_zero,
   output logic                 rsp_overflow,
   output logic                 busy
`ifdef ALU_SEQ_STICKY_OVF_EN
   ,
   output logic                 ovf_sticky,
   input  logic                 ovf_clear
`endif
);

   logic                 s1_valid;
   logic                 s2_valid;
   logic [OPERATION-1:0] s1_op;
   logic [WIDTH-1:0]     s1_x;
   logic [WIDTH-1:0]     s1_y;
   logic [SHIFT-1:0]     s1_shamt;
   logic                 s1_carry;
   logic                 s1_chain;
   logic [WIDTH-1:0]     acc;

   logic                 s1_adv;
   logic                 s2_adv;
   logic                 accept;
   logic [WIDTH-1:0]     alu_x;
   logic [WIDTH-1:0]     alu_result;
   logic                 alu_zero;
   logic                 alu_overflow;

   // Handshake: a full pipe still accepts when the response is popped this cycle.
   assign s2_adv    = !s2_valid || rsp_ready;
   assign s1_adv    = s1_valid && s2_adv;
   assign cmd_ready = !s1_valid || s1_adv;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = s1_valid || s2_valid;
   assign rsp_valid = s2_valid;

   // In-order flow means acc always holds the preceding command's result.
   assign alu_x = s1_chain ? acc : s1_x;

   alu #(
      .WIDTH     (WIDTH),
      .OPERATION (OPERATION),
      .SHIFT     (SHIFT)
   ) u_alu (
      .op         (s1_op),
      .x          (alu_x),
      .y          (s1_y),
      .shamt      (s1_shamt),
      .carry      (s1_carry),
      .result_c   (alu_result),
      .zero_c     (alu_zero),
      .overflow_c (alu_overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         acc          <= '0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         if (cmd_ready) s1_valid <= cmd_valid;
         if (s2_adv)    s2_valid <= s1_valid;
         if (s1_adv) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            acc          <= alu_result;
         end
      end
   end

   // Operand payload needs no reset; s1_valid qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op    <= cmd_op;
         s1_x     <= cmd_x;
         s1_y     <= cmd_y;
         s1_shamt <= cmd_shamt;
         s1_carry <= cmd_carry;
         s1_chain <= cmd_chain;
      end
   end

`ifdef ALU_SEQ_STICKY_OVF_EN
   // Set on an overflowing response handshake; set wins over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (s2_valid && rsp_ready && rsp_overflow) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clear) begin
         ovf_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, hand-written flow-control sequences
// and a randomized run against a queue-based reference model.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int unsigned W = DEF_WIDTH;

   typedef struct {
      logic [2:0] op;
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] sh;
      logic       c;
      logic       ch;
      logic [7:0] res;
      logic       z;
      logic       o;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_x;
   logic [7:0] cmd_y;
   logic [2:0] cmd_shamt;
   logic       cmd_carry;
   logic       cmd_chain;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic       rsp_overflow;
   logic       busy;
`ifdef ALU_SEQ_STICKY_OVF_EN
   logic       ovf_sticky;
   logic       ovf_clear;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_shamt    (cmd_shamt),
      .cmd_carry    (cmd_carry),
      .cmd_chain    (cmd_chain),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
`ifdef ALU_SEQ_STICKY_OVF_EN
      ,
      .ovf_sticky   (ovf_sticky),
      .ovf_clear    (ovf_clear)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model from the opcode definitions using plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                  input logic [2:0] sh, input logic c);
      exp_t e;
      int ux, uy, sx, sy, s;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
      sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
      e.o = 1'b0;
      case (op)
         OP_ADD: begin
            e.res = 8'(ux + uy + int'(c));
            s = sx + sy + int'(c);
            e.o = (s > 127) || (s < -128);
         end
         OP_SUB: begin
            e.res = 8'(ux - uy);
            s = sx - sy;
            e.o = (s > 127) || (s < -128);
         end
         OP_AND:  e.res = x & y;
         OP_OR:   e.res = x | y;
         OP_XOR:  e.res = x ^ y;
         OP_NOR:  e.res = ~(x | y);
         OP_SLL:  e.res = 8'(ux << int'(sh));
         default: e.res = 8'(ux >> int'(sh));
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] sh, input logic c, input logic ch);
      cmd_op = op; cmd_x = x; cmd_y = y; cmd_shamt = sh; cmd_carry = c; cmd_chain = ch;
   endtask

   // One isolated transaction with rsp_ready=1: checks latency and the response.
   task automatic one(input vec_t v, input string tag);
      @(negedge clk);
      drive(v.op, v.x, v.y, v.sh, v.c, v.ch);
      cmd_valid = 1'b1;
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_lat1_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_result"}, 32'(rsp_result), 32'(v.res));
      chk({tag, "_zero"}, 32'(rsp_zero), 32'(v.z));
      chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(v.o));
   endtask

   vec_t vt[16];
   exp_t exp_q[$];
   exp_t ea, eb, ec;
   vec_t v;
   logic [7:0] model_acc;
   logic [7:0] xe;

   initial begin
      vt[0]  = '{OP_ADD, 8'hAA, 8'h01, 3'd0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      vt[1]  = '{OP_ADD, 8'h05, 8'h03, 3'd0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
      vt[2]  = '{OP_ADD, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[3]  = '{OP_SUB, 8'h10, 8'h10, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[4]  = '{OP_ADD, 8'h02, 8'h03, 3'd0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
      vt[5]  = '{OP_SLL, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b1, 8'h14, 1'b0, 1'b0};
      vt[6]  = '{OP_SUB, 8'h00, 8'h15, 3'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[7]  = '{OP_AND, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
      vt[8]  = '{OP_OR,  8'hF0, 8'h0C, 3'd0, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0};
      vt[9]  = '{OP_XOR, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0};
      vt[10] = '{OP_NOR, 8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[11] = '{OP_SRL, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
      vt[12] = '{OP_SUB, 8'h80, 8'h01, 3'd0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};
      vt[13] = '{OP_ADD, 8'hFF, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[14] = '{OP_SLL, 8'h81, 8'h00, 3'd1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
      vt[15] = '{OP_AND, 8'h00, 8'h03, 3'd0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};

      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
      drive(OP_ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`ifdef ALU_SEQ_STICKY_OVF_EN
      ovf_clear = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_result", 32'(rsp_result), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) one(vt[i], $sformatf("vec%0d", i));

      // Backpressure: third command stalls, response held stable, then in-order drain.
      @(negedge clk);
      rsp_ready = 1'b0;
      ea = model(OP_ADD, 8'h11, 8'h22, 3'd0, 1'b0);
      eb = model(OP_SUB, 8'h05, 8'h09, 3'd0, 1'b0);
      ec = model(OP_OR,  8'h40, 8'h02, 3'd0, 1'b0);
      drive(OP_ADD, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      #1 chk("bp_acc_a", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      drive(OP_SUB, 8'h05, 8'h09, 3'd0, 1'b0, 1'b0);
      #1 chk("bp_acc_b", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      drive(OP_OR, 8'h40, 8'h02, 3'd0, 1'b0, 1'b0);
      #1 chk("bp_ready_drop", 32'(cmd_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_hold_ready", 32'(cmd_ready), 32'd0);
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_result", 32'(rsp_result), 32'(ea.res));
         chk("bp_hold_zero", 32'(rsp_zero), 32'(ea.z));
      end
      rsp_ready = 1'b1;
      #1 chk("bp_pop_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp_b_valid", 32'(rsp_valid), 32'd1);
      chk("bp_b_result", 32'(rsp_result), 32'(eb.res));
      @(negedge clk);
      chk("bp_c_valid", 32'(rsp_valid), 32'd1);
      chk("bp_c_result", 32'(rsp_result), 32'(ec.res));
      @(negedge clk);
      chk("bp_empty_valid", 32'(rsp_valid), 32'd0);
      chk("bp_empty_busy", 32'(busy), 32'd0);

      // Reset with both stages full discards everything.
      rsp_ready = 1'b0;
      drive(OP_ADD, 8'h33, 8'h44, 3'd0, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_full_busy", 32'(busy), 32'd1);
      chk("mid_full_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmd_valid = 1'b0;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_result", 32'(rsp_result), 32'd0);
      // A command presented during reset is dropped.
      rst = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmd_valid = 1'b0;
      chk("rst_drop_busy", 32'(busy), 32'd0);
      rsp_ready = 1'b1;
      v = '{OP_ADD, 8'h5A, 8'h01, 3'd0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      one(v, "chain_after_rst");

      // Randomized run against the queue model.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_acc = 8'h00;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         chk("rnd_valid_unexpected", 32'(rsp_valid && exp_q.size() == 0), 32'd0);
         if (rsp_valid && exp_q.size() != 0) begin
            chk("rnd_result", 32'(rsp_result), 32'(exp_q[0].res));
            chk("rnd_zero", 32'(rsp_zero), 32'(exp_q[0].z));
            chk("rnd_ovf", 32'(rsp_overflow), 32'(exp_q[0].o));
         end
         chk("rnd_busy", 32'(busy), 32'(exp_q.size() != 0));
         rsp_ready = ($urandom_range(0, 3) != 0);
         cmd_valid = ($urandom_range(0, 2) != 0);
         drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         #1;
         chk("rnd_cmd_ready", 32'(cmd_ready), 32'(exp_q.size() < 2 || rsp_ready));
         if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (cmd_valid && cmd_ready) begin
            xe = cmd_chain ? model_acc : cmd_x;
            ea = model(cmd_op, xe, cmd_y, cmd_shamt, cmd_carry);
            exp_q.push_back(ea);
            model_acc = ea.res;
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 10 && (exp_q.size() != 0 || busy); k++) begin
         if (rsp_valid && exp_q.size() != 0) begin
            chk("drain_result", 32'(rsp_result), 32'(exp_q[0].res));
            void'(exp_q.pop_front());
         end
         @(negedge clk);
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);

`ifdef ALU_SEQ_STICKY_OVF_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("sticky_rst", 32'(ovf_sticky), 32'd0);
      v = '{OP_ADD, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      one(v, "sticky_ovf");
      @(negedge clk);
      chk("sticky_set", 32'(ovf_sticky), 32'd1);
      v = '{OP_ADD, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
      one(v, "sticky_noovf");
      @(negedge clk);
      chk("sticky_hold", 32'(ovf_sticky), 32'd1);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      chk("sticky_clear", 32'(ovf_sticky), 32'd0);
      rsp_ready = 1'b0;
      drive(OP_ADD, 8'h7F, 8'h01, 3'd0, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("sticky_pend_valid", 32'(rsp_valid), 32'd1);
      chk("sticky_pend", 32'(ovf_sticky), 32'd0);
      ovf_clear = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
      chk("sticky_popped", 32'(rsp_valid), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
